// File: rtl/rf_wb_sched_if.sv
// Bundle of issue, writeback-source, hazard-query and register-file-write signals
// for the register file writeback scheduler.
interface rf_wb_sched_if #(
    parameter int DW = 32,
    parameter int AW = 5
);
    logic                 iss_valid;
    logic [AW-1:0]        iss_rd;
    logic                 iss_stall;

    logic                 alu_valid;
    logic [AW-1:0]        alu_rd;
    logic [DW-1:0]        alu_d;
    logic                 alu_ready;

    logic                 mem_valid;
    logic [AW-1:0]        mem_rd;
    logic [DW-1:0]        mem_d;
    logic                 mem_ready;

    logic [AW-1:0]        rna;
    logic [AW-1:0]        rnb;
    logic                 busy_a;
    logic                 busy_b;

    logic [AW-1:0]        wn;
    logic [DW-1:0]        d;
    logic                 we;
    logic [(1<<AW)-1:0]   pend;

    modport master (
        output iss_valid, iss_rd, alu_valid, alu_rd, alu_d,
               mem_valid, mem_rd, mem_d, rna, rnb,
        input  iss_stall, alu_ready, mem_ready, busy_a, busy_b,
               wn, d, we, pend
    );

    modport slave (
        input  iss_valid, iss_rd, alu_valid, alu_rd, alu_d,
               mem_valid, mem_rd, mem_d, rna, rnb,
        output iss_stall, alu_ready, mem_ready, busy_a, busy_b,
               wn, d, we, pend
    );
endinterface

// File: rtl/rf_wb_sched.sv
// Round-robin writeback arbiter (ALU vs MEM) onto the single register file write
// port, plus a per-register pending scoreboard for RAW/WAW hazard detection.
module rf_wb_sched #(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic           clk,
    input  logic           clr,
    rf_wb_sched_if.slave   bus
);
    localparam int NR = 1 << AW;

    logic          r_pri;
    logic          r_we;
    logic [AW-1:0] r_wn;
    logic [DW-1:0] r_d;
    logic [NR-1:0] r_pend;

    logic w_alu_grant;
    logic w_mem_grant;
    logic w_iss_stall;
    logic w_set;

    // r_pri=0 favours ALU on contention, r_pri=1 favours MEM.
    assign w_alu_grant = bus.alu_valid & (~bus.mem_valid | ~r_pri);
    assign w_mem_grant = bus.mem_valid & (~bus.alu_valid |  r_pri);

    // Stall decision uses the registered scoreboard only, ignoring a same-cycle clear.
    assign w_iss_stall = bus.iss_valid & r_pend[bus.iss_rd] & (bus.iss_rd != '0);
    assign w_set       = bus.iss_valid & ~w_iss_stall & (bus.iss_rd != '0);

    assign bus.alu_ready = w_alu_grant;
    assign bus.mem_ready = w_mem_grant;
    assign bus.iss_stall = w_iss_stall;
    assign bus.busy_a    = r_pend[bus.rna];
    assign bus.busy_b    = r_pend[bus.rnb];
    assign bus.wn        = r_wn;
    assign bus.d         = r_d;
    assign bus.we        = r_we;
    assign bus.pend      = r_pend;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_we  <= 1'b0;
            r_wn  <= '0;
            r_d   <= '0;
            r_pri <= 1'b0;
        end else if (w_alu_grant) begin
            r_wn  <= bus.alu_rd;
            r_d   <= bus.alu_d;
            r_we  <= (bus.alu_rd != '0);
            r_pri <= 1'b1;
        end else if (w_mem_grant) begin
            r_wn  <= bus.mem_rd;
            r_d   <= bus.mem_d;
            r_we  <= (bus.mem_rd != '0);
            r_pri <= 1'b0;
        end else begin
            r_we  <= 1'b0;
        end
    end

    // Bit 0 can never be set nor cleared (iss_rd=0 and we for r0 are both suppressed).
    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_pend
            always_ff @(posedge clk) begin
                if (clr) begin
                    r_pend[gi] <= 1'b0;
                end else if (w_set && (bus.iss_rd == AW'(gi))) begin
                    r_pend[gi] <= 1'b1;
                end else if (r_we && (r_wn == AW'(gi))) begin
                    r_pend[gi] <= 1'b0;
                end
            end
        end
    endgenerate
endmodule

// File: doc/rf_wb_sched.md
Name: rf_wb_sched

Overview:
- Writeback scheduler for the 32x32 two-read/one-write register file.
- Shares the single write port (wn/d/we) between two writeback sources, ALU and MEM, using round-robin arbitration.
- Keeps a per-register pending scoreboard. The issue stage uses it to detect RAW hazards on the two read-port addresses and WAW hazards on the destination.
- Sits between the execute/memory stages and the register file write port.

Parameters:
- DW, 32, data width of the write port.
- AW, 5, register address width; the block covers 2**AW registers.

Ports:
- clk  in  1  clock
- clr  in  1  synchronous active-high reset
- iss_valid  in  1  issue stage allocates a destination this cycle
- iss_rd  in  AW  destination register being allocated
- iss_stall  out  1  allocation refused (WAW), combinational
- alu_valid  in  1  ALU writeback request
- alu_rd  in  AW  ALU destination
- alu_d  in  DW  ALU result
- alu_ready  out  1  ALU request granted this cycle, combinational
- mem_valid  in  1  MEM writeback request
- mem_rd  in  AW  MEM destination
- mem_d  in  DW  MEM result
- mem_ready  out  1  MEM request granted this cycle, combinational
- rna  in  AW  read-port A address under check
- rnb  in  AW  read-port B address under check
- busy_a  out  1  pend[rna], combinational
- busy_b  out  1  pend[rnb], combinational
- wn  out  AW  register file write address, registered
- d  out  DW  register file write data, registered
- we  out  1  register file write enable, registered
- pend  out  2**AW  pending-write vector, registered; bit 0 is always 0

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on clr. While clr=1 at a rising edge:
  - we=0, wn=0, d=0, pend=0, pri=0.
  - Combinational readies still evaluate; any grant in that cycle is discarded.
- Handshake:
  - A source holds valid, rd and d stable until it sees ready=1.
  - A transfer occurs at the edge where valid=1 and ready=1.
  - ready is never asserted without valid.
- Arbitration:
  - One grant per cycle, no bubbles.
  - Only one source valid: that source is granted.
  - Both valid: pri=0 grants ALU, pri=1 grants MEM.
  - After any grant, pri points at the non-granted source.
  - Under continuous contention the grants alternate.
- Write stage, one register level:
  - At the grant edge: wn<=rd, d<=data, we<=(rd!=0).
  - Edge with no grant: we<=0; wn and d hold their previous values.
  - Latency: data reaches the register file at the edge after the grant cycle, where we is high.
- r0: a writeback to r0 is granted normally but produces we=0.
- Scoreboard set:
  - At an edge with iss_valid=1, iss_stall=0 and iss_rd!=0, pend[iss_rd]<=1.
- Scoreboard clear:
  - At an edge with we=1, pend[wn]<=0.
  - The clear coincides with the register file write, so busy drops only when the data is readable.
- Simultaneous set and clear of the same register: set wins, pend stays 1.
- iss_stall:
  - iss_stall = iss_valid & pend[iss_rd] & (iss_rd!=0).
  - It ignores a clear happening in the same cycle, so the decision is conservative.
  - iss_rd=0 never stalls and never sets a bit.
- Writeback to a non-pending register is allowed; the clear is a no-op.
- Reset mid-operation:
  - An in-flight write (we=1 at the clr edge) is dropped.
  - Sources must re-present their request after clr deasserts.

Test Plan:
- clr=1 for 2 cycles with alu_valid=1 -> we=0, wn=0, d=0, pend=0 after release; the ALU request is granted in the first cycle after clr=0.
- alu_valid=1, alu_rd=5, alu_d=0xDEADBEEF, mem_valid=0 -> alu_ready=1 that cycle; next cycle we=1, wn=5, d=0xDEADBEEF; the cycle after, we=0.
- alu_valid and mem_valid held 1 with rd=3/7 and d=0x11/0x22, both sources advancing on their own ready -> grants ALU, MEM, ALU, MEM...; wn sequence 3,7,3,7 one cycle later; no idle cycles.
- iss rd=9, then rna=9 -> busy_a=1; MEM writes rd=9 -> busy_a stays 1 through the we cycle and is 0 the cycle after; a second iss rd=9 while pending -> iss_stall=1, pend unchanged.
- iss rd=12 at the same edge where we=1 with wn=12 -> pend[12]=1 afterwards, busy_b (rnb=12)=1.
- alu_rd=0, alu_d=0xFFFFFFFF -> alu_ready=1, next-cycle we=0; iss rd=0 -> iss_stall=0, pend[0]=0.
